// File: rtl/ip_ram_arbiter.sv
// ip_ram_arbiter
//   Shares one external RAM controller command port between two requesters
//   (A and B), e.g. two ROM/mapper slot front-ends. Each requester holds
//   rd or wr high as a level for its whole bus cycle. The arbiter turns
//   every assertion into exactly one RAM command. Requests are granted
//   round-robin, and read data is routed back to whichever port issued the
//   read. Only one transaction is outstanding at a time. A read that never
//   gets its data strobe is completed with 8'hFF after TIMEOUT cycles.
//
// Parameters
//   TIMEOUT       cycles spent waiting for read data before forcing 8'hFF (2..255)
//   PRIO_A_FIRST  port that wins the first contended grant after reset (1 = A)
//
// Ports
//   clk, reset                 clock, synchronous active-high reset
//   x_rd / x_wr                level-held read / write request (x = a, b)
//   x_address / x_wdata        request byte address / write data
//   x_busy                     request pending or currently in flight for x
//   x_rdata / x_rdata_en       read data and its one-cycle strobe to x
//   ram_rd / ram_wr            one-cycle command pulses to the RAM controller
//   ram_address / ram_wdata    registered command address / write data
//   ram_busy                   controller cannot take a command this cycle
//   ram_rdata / ram_rdata_en   controller read data and its strobe
module ip_ram_arbiter #(
  parameter int unsigned TIMEOUT      = 64,
  parameter bit          PRIO_A_FIRST = 1'b1
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        a_rd,
  input  logic        a_wr,
  input  logic [21:0] a_address,
  input  logic [7:0]  a_wdata,
  output logic        a_busy,
  output logic [7:0]  a_rdata,
  output logic        a_rdata_en,
  input  logic        b_rd,
  input  logic        b_wr,
  input  logic [21:0] b_address,
  input  logic [7:0]  b_wdata,
  output logic        b_busy,
  output logic [7:0]  b_rdata,
  output logic        b_rdata_en,
  output logic        ram_rd,
  output logic        ram_wr,
  output logic [21:0] ram_address,
  output logic [7:0]  ram_wdata,
  input  logic        ram_busy,
  input  logic [7:0]  ram_rdata,
  input  logic        ram_rdata_en
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_ISSUE = 2'd1,
    S_WAIT  = 2'd2
  } state_e;

  localparam logic [7:0] TO_LAST = 8'(TIMEOUT - 1);

  state_e      state_q, state_d;
  logic        owner_q, owner_d;       // 0 = A, 1 = B
  logic        is_rd_q, is_rd_d;
  logic [21:0] addr_q, addr_d;
  logic [7:0]  wdata_q, wdata_d;
  logic        served_a_q, served_a_d;
  logic        served_b_q, served_b_d;
  logic        rr_q, rr_d;             // 1 = A wins a contended grant
  logic [7:0]  cnt_q, cnt_d;
  logic        ram_rd_q, ram_rd_d;
  logic        ram_wr_q, ram_wr_d;
  logic [7:0]  a_rdata_q, a_rdata_d;
  logic [7:0]  b_rdata_q, b_rdata_d;
  logic        a_en_q, a_en_d;
  logic        b_en_q, b_en_d;

  logic        act_a, act_b;
  logic        req_a, req_b;
  logic        issue;
  logic        grant_b;
  logic        rd_done;
  logic [7:0]  rdata_sel;

  // A port is active while either level is high; it requests only until
  // its command has gone out, so a held level yields a single transaction.
  assign act_a = a_rd | a_wr;
  assign act_b = b_rd | b_wr;
  assign req_a = act_a & ~served_a_q;
  assign req_b = act_b & ~served_b_q;

  assign issue   = (state_q == S_ISSUE) & ~ram_busy;
  assign rd_done = (state_q == S_WAIT) & (ram_rdata_en | (cnt_q == TO_LAST));

  // Data strobe wins over a timeout landing in the same cycle.
  assign rdata_sel = ram_rdata_en ? ram_rdata : 8'hFF;

  assign a_busy = req_a | ((state_q != S_IDLE) & ~owner_q);
  assign b_busy = req_b | ((state_q != S_IDLE) &  owner_q);

  always_comb begin
    state_d   = state_q;
    owner_d   = owner_q;
    is_rd_d   = is_rd_q;
    addr_d    = addr_q;
    wdata_d   = wdata_q;
    rr_d      = rr_q;
    cnt_d     = cnt_q;
    ram_rd_d  = 1'b0;
    ram_wr_d  = 1'b0;
    a_rdata_d = a_rdata_q;
    b_rdata_d = b_rdata_q;
    a_en_d    = 1'b0;
    b_en_d    = 1'b0;
    grant_b   = 1'b0;

    // Served flags clear whenever the level drops, even mid-transaction,
    // so the next assertion is seen as a fresh request. A drop in the
    // issuing cycle wins over the set.
    served_a_d = act_a & (served_a_q | (issue & ~owner_q));
    served_b_d = act_b & (served_b_q | (issue &  owner_q));

    case (state_q)
      S_IDLE: begin
        if (req_a | req_b) begin
          grant_b = req_b & (~req_a | ~rr_q);
          owner_d = grant_b;
          addr_d  = grant_b ? b_address : a_address;
          wdata_d = grant_b ? b_wdata   : a_wdata;
          // rd and wr together is treated as a read
          is_rd_d = grant_b ? b_rd      : a_rd;
          state_d = S_ISSUE;
        end
      end

      S_ISSUE: begin
        if (!ram_busy) begin
          ram_rd_d = is_rd_q;
          ram_wr_d = ~is_rd_q;
          // Hand priority to the port that did not just issue:
          // owner B (1) gives rr = 1 (A first), owner A (0) gives rr = 0.
          rr_d     = owner_q;
          cnt_d    = 8'd0;
          state_d  = is_rd_q ? S_WAIT : S_IDLE;
        end
      end

      S_WAIT: begin
        if (rd_done) begin
          if (owner_q) begin
            b_rdata_d = rdata_sel;
            b_en_d    = 1'b1;
          end else begin
            a_rdata_d = rdata_sel;
            a_en_d    = 1'b1;
          end
          state_d = S_IDLE;
        end else begin
          cnt_d = cnt_q + 8'd1;
        end
      end

      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= S_IDLE;
      owner_q    <= 1'b0;
      is_rd_q    <= 1'b0;
      addr_q     <= 22'd0;
      wdata_q    <= 8'd0;
      served_a_q <= 1'b0;
      served_b_q <= 1'b0;
      rr_q       <= PRIO_A_FIRST;
      cnt_q      <= 8'd0;
      ram_rd_q   <= 1'b0;
      ram_wr_q   <= 1'b0;
      a_rdata_q  <= 8'd0;
      b_rdata_q  <= 8'd0;
      a_en_q     <= 1'b0;
      b_en_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      owner_q    <= owner_d;
      is_rd_q    <= is_rd_d;
      addr_q     <= addr_d;
      wdata_q    <= wdata_d;
      served_a_q <= served_a_d;
      served_b_q <= served_b_d;
      rr_q       <= rr_d;
      cnt_q      <= cnt_d;
      ram_rd_q   <= ram_rd_d;
      ram_wr_q   <= ram_wr_d;
      a_rdata_q  <= a_rdata_d;
      b_rdata_q  <= b_rdata_d;
      a_en_q     <= a_en_d;
      b_en_q     <= b_en_d;
    end
  end

  // Command pulses are registered, so they appear the cycle after the
  // ISSUE cycle that accepted them. The address is latched at grant and
  // only changes on the next grant, so it is stable under the pulse.
  assign ram_rd      = ram_rd_q;
  assign ram_wr      = ram_wr_q;
  assign ram_address = addr_q;
  assign ram_wdata   = wdata_q;
  assign a_rdata     = a_rdata_q;
  assign a_rdata_en  = a_en_q;
  assign b_rdata     = b_rdata_q;
  assign b_rdata_en  = b_en_q;

endmodule

// File: tb/tb_ip_ram_arbiter.sv
// Bench for ip_ram_arbiter: directed scenarios followed by randomized
// two-port traffic against a transaction-level model (memory behind the
// RAM controller, per-port pending request, round-robin fairness rule).
module tb_ip_ram_arbiter;

  localparam int TO = 8;
  localparam int NRAND = 60;

  logic        clk = 1'b0;
  logic        reset;
  logic        a_rd, a_wr, b_rd, b_wr;
  logic [21:0] a_address, b_address;
  logic [7:0]  a_wdata, b_wdata;
  logic        a_busy, b_busy;
  logic [7:0]  a_rdata, b_rdata;
  logic        a_rdata_en, b_rdata_en;
  logic        ram_rd, ram_wr;
  logic [21:0] ram_address;
  logic [7:0]  ram_wdata;
  logic        ram_busy;
  logic [7:0]  ram_rdata;
  logic        ram_rdata_en;

  ip_ram_arbiter #(.TIMEOUT(TO), .PRIO_A_FIRST(1'b1)) dut (
    .clk(clk), .reset(reset),
    .a_rd(a_rd), .a_wr(a_wr), .a_address(a_address), .a_wdata(a_wdata),
    .a_busy(a_busy), .a_rdata(a_rdata), .a_rdata_en(a_rdata_en),
    .b_rd(b_rd), .b_wr(b_wr), .b_address(b_address), .b_wdata(b_wdata),
    .b_busy(b_busy), .b_rdata(b_rdata), .b_rdata_en(b_rdata_en),
    .ram_rd(ram_rd), .ram_wr(ram_wr), .ram_address(ram_address),
    .ram_wdata(ram_wdata), .ram_busy(ram_busy), .ram_rdata(ram_rdata),
    .ram_rdata_en(ram_rdata_en)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_chk = 0;
  int n_pass = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", tag, obs, exp, cyc);
  endtask

  task automatic tick();
    @(negedge clk);
    #1;
  endtask

  // RAM contents seen through the controller; unwritten bytes read back
  // as a fixed function of the address.
  logic [7:0] mem [int];

  function automatic logic [7:0] mem_val(input logic [21:0] ad);
    if (mem.exists(int'(ad))) return mem[int'(ad)];
    return ad[7:0] ^ 8'h3C;
  endfunction

  // RAM controller model: answers each ram_rd after resp_lat cycles
  // (-1 = never), or after a random latency in random mode.
  int         resp_lat = 3;
  bit         rand_on = 1'b0;
  int         lat_left = -1;
  logic [7:0] resp_val;
  logic [7:0] exp_data [2];

  initial begin
    int lat;
    ram_rdata    = 8'd0;
    ram_rdata_en = 1'b0;
    forever begin
      @(negedge clk);
      ram_rdata_en = 1'b0;
      if (ram_wr) mem[int'(ram_address)] = ram_wdata;
      if (ram_rd) begin
        lat = resp_lat;
        if (rand_on) begin
          lat = $urandom_range(0, 8);
          if (lat > 6) lat = -1;
        end
        resp_val = mem_val(ram_address);
        exp_data[ram_address[21]] = (lat < 0) ? 8'hFF : resp_val;
        lat_left = lat;
      end
      if (lat_left == 0) begin
        ram_rdata_en = 1'b1;
        ram_rdata    = resp_val;
        lat_left     = -1;
      end else if (lat_left > 0) begin
        lat_left--;
      end
    end
  end

  // Event recorder plus the random-phase transaction checks.
  int         n_rd = 0, n_wr = 0, n_aen = 0, n_ben = 0;
  int         last_rd_cyc, last_wr_cyc, last_aen_cyc, last_ben_cyc;
  logic [21:0] last_cmd_addr;
  logic [7:0] last_wdata, last_a_rdata, last_b_rdata;
  bit         owner_hist [$];

  bit          pend [2], issued [2], rd_wait [2], got [2], pend_rd [2];
  logic [21:0] pend_addr [2];
  logic [7:0]  pend_wdata [2];
  int          pend_start [2];
  int          prev_cmd_cyc;
  bit          have_prev, prev_owner;

  initial begin
    bit p, o;
    forever begin
      @(negedge clk);
      if (ram_rd | ram_wr) begin
        p = ram_address[21];
        owner_hist.push_back(p);
        last_cmd_addr = ram_address;
        if (ram_rd) begin n_rd++; last_rd_cyc = cyc; end
        if (ram_wr) begin n_wr++; last_wr_cyc = cyc; last_wdata = ram_wdata; end
        if (rand_on) begin
          chk("cmd_exclusive", 32'(ram_rd & ram_wr), 0);
          chk("cmd_pending", 32'(pend[p] & ~issued[p]), 1);
          chk("cmd_addr", 32'(ram_address), 32'(pend_addr[p]));
          chk("cmd_kind", 32'(ram_rd), 32'(pend_rd[p]));
          if (ram_wr) chk("cmd_wdata", 32'(ram_wdata), 32'(pend_wdata[p]));
          // A port left waiting across the previous command must win next.
          o = !prev_owner;
          if (have_prev && pend[o] && !issued[o] && pend_start[o] <= prev_cmd_cyc)
            chk("rr_alternate", 32'(p), 32'(o));
          issued[p] = 1'b1;
          if (ram_rd) rd_wait[p] = 1'b1;
          have_prev    = 1'b1;
          prev_owner   = p;
          prev_cmd_cyc = cyc;
        end
      end
      if (a_rdata_en) begin
        n_aen++; last_aen_cyc = cyc; last_a_rdata = a_rdata;
        if (rand_on) begin
          chk("a_en_expected", 32'(rd_wait[0]), 1);
          chk("a_rdata", 32'(a_rdata), 32'(exp_data[0]));
          rd_wait[0] = 1'b0; got[0] = 1'b1;
        end
      end
      if (b_rdata_en) begin
        n_ben++; last_ben_cyc = cyc; last_b_rdata = b_rdata;
        if (rand_on) begin
          chk("b_en_expected", 32'(rd_wait[1]), 1);
          chk("b_rdata", 32'(b_rdata), 32'(exp_data[1]));
          rd_wait[1] = 1'b0; got[1] = 1'b1;
        end
      end
    end
  end

  function automatic int cnt_of(input int sel);
    case (sel)
      0: return n_rd;
      1: return n_wr;
      2: return n_aen;
      default: return n_ben;
    endcase
  endfunction

  task automatic wait_ev(input int sel, input int base);
    int w;
    w = 0;
    while (cnt_of(sel) <= base && w < 60) begin tick(); w++; end
  endtask

  task automatic drive_port(input bit p, input logic rd, input logic wr,
                            input logic [21:0] ad, input logic [7:0] wd);
    if (!p) begin a_rd = rd; a_wr = wr; a_address = ad; a_wdata = wd; end
    else    begin b_rd = rd; b_wr = wr; b_address = ad; b_wdata = wd; end
  endtask

  task automatic req_loop(input bit p, input int n);
    logic [21:0] ad;
    logic [7:0]  wd;
    bit          isrd;
    int          w;
    for (int i = 0; i < n; i++) begin
      repeat ($urandom_range(1, 3)) tick();
      ad   = {p, 17'b0, 4'($urandom)};
      wd   = 8'($urandom);
      isrd = 1'($urandom_range(0, 1));
      pend_addr[p] = ad; pend_wdata[p] = wd; pend_rd[p] = isrd;
      issued[p] = 1'b0; got[p] = 1'b0; pend_start[p] = cyc; pend[p] = 1'b1;
      drive_port(p, isrd, isrd ? 1'($urandom_range(0, 1)) : 1'b1, ad, wd);
      w = 0;
      while (!issued[p] && w < 300) begin tick(); w++; end
      chk("issue_wait", 32'(issued[p]), 1);
      if (isrd) begin
        w = 0;
        while (!got[p] && w < 300) begin tick(); w++; end
        chk("data_wait", 32'(got[p]), 1);
      end
      drive_port(p, 1'b0, 1'b0, ad, wd);
      pend[p] = 1'b0;
    end
  endtask

  initial begin
    #400000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int  b_rd0, b_wr0, b_aen0, b_ben0, t0, rel, hb, ord, base_cmd;
    bit  done;
    reset = 1'b1;
    a_rd = 0; a_wr = 0; a_address = '0; a_wdata = '0;
    b_rd = 0; b_wr = 0; b_address = '0; b_wdata = '0;
    ram_busy = 1'b0;
    tick(); tick();

    // reset state
    chk("rst_strobes", 32'({ram_rd, ram_wr, a_rdata_en, b_rdata_en, a_busy, b_busy}), 0);
    chk("rst_ram_address", 32'(ram_address), 0);
    chk("rst_data", 32'({ram_wdata, a_rdata, b_rdata}), 0);
    reset = 1'b0;
    tick();

    // single read from A
    mem[int'(22'h012345)] = 8'h5A;
    resp_lat = 3;
    b_rd0 = n_rd; b_aen0 = n_aen; b_ben0 = n_ben;
    a_address = 22'h012345; a_rd = 1'b1; t0 = cyc;
    #1;
    chk("t1_a_busy", 32'(a_busy), 1);
    wait_ev(0, b_rd0);
    chk("t1_rd_count", n_rd - b_rd0, 1);
    chk("t1_rd_latency", last_rd_cyc - t0, 2);
    chk("t1_addr", 32'(last_cmd_addr), 32'h012345);
    wait_ev(2, b_aen0);
    chk("t1_aen_latency", last_aen_cyc - last_rd_cyc, 4);
    chk("t1_a_rdata", 32'(last_a_rdata), 32'h5A);
    chk("t1_no_b_en", n_ben - b_ben0, 0);

    // held level: one transaction only, re-arm after a one-cycle drop
    repeat (31) tick();
    chk("t2_held_one", n_rd - b_rd0, 1);
    chk("t2_busy_served", 32'(a_busy), 0);
    a_rd = 1'b0; tick(); a_rd = 1'b1;
    wait_ev(0, b_rd0 + 1);
    chk("t2_rearm", n_rd - b_rd0, 2);
    wait_ev(2, b_aen0 + 1);
    a_rd = 1'b0; tick(); tick();

    // contention right after reset
    reset = 1'b1; tick(); reset = 1'b0;
    resp_lat = 2;
    b_rd0 = n_rd; b_wr0 = n_wr; b_aen0 = n_aen; hb = owner_hist.size();
    a_address = 22'h000100; b_address = 22'h200200; b_wdata = 8'hC3;
    a_rd = 1'b1; b_wr = 1'b1;
    wait_ev(0, b_rd0);
    chk("t3_first_addr", 32'(last_cmd_addr), 32'h000100);
    chk("t3_no_wr_yet", n_wr - b_wr0, 0);
    wait_ev(1, b_wr0);
    chk("t3_b_wdata", 32'(last_wdata), 32'hC3);
    chk("t3_b_addr", 32'(last_cmd_addr), 32'h200200);
    chk("t3_a_data_first", n_aen - b_aen0, 1);
    chk("t3_wr_after_data", 32'(last_wr_cyc > last_aen_cyc), 1);
    a_rd = 1'b0; b_wr = 1'b0; tick(); tick();
    a_rd = 1'b1; b_wr = 1'b1;
    wait_ev(1, b_wr0 + 1);
    a_rd = 1'b0; b_wr = 1'b0; tick(); tick();
    chk("t3_cmd_count", owner_hist.size() - hb, 4);
    ord = 0;
    for (int i = 0; i < 4 && hb + i < owner_hist.size(); i++) ord = (ord << 1) | int'(owner_hist[hb + i]);
    chk("t3_owner_order", ord, 32'b0101);

    // backpressure in ISSUE
    ram_busy = 1'b1; resp_lat = 1;
    b_rd0 = n_rd; b_ben0 = n_ben;
    b_address = 22'h200777; b_rd = 1'b1;
    repeat (6) tick();
    chk("t4_no_rd_busy", n_rd - b_rd0, 0);
    rel = cyc; ram_busy = 1'b0;
    wait_ev(0, b_rd0);
    chk("t4_rd_count", n_rd - b_rd0, 1);
    chk("t4_rd_when_free", last_rd_cyc - rel, 1);
    chk("t4_addr", 32'(last_cmd_addr), 32'h200777);
    wait_ev(3, b_ben0);
    chk("t4_b_rdata", 32'(last_b_rdata), 32'(mem_val(22'h200777)));
    b_rd = 1'b0; tick();

    // read timeout, then B is still served
    resp_lat = -1;
    b_rd0 = n_rd; b_aen0 = n_aen; b_ben0 = n_ben;
    a_address = 22'h000ABC; a_rd = 1'b1;
    wait_ev(0, b_rd0);
    wait_ev(2, b_aen0);
    chk("t5_aen_count", n_aen - b_aen0, 1);
    chk("t5_timeout_latency", last_aen_cyc - last_rd_cyc, TO);
    chk("t5_a_rdata_ff", 32'(last_a_rdata), 32'hFF);
    a_rd = 1'b0; tick();
    resp_lat = 2;
    b_address = 22'h200ABC; b_rd = 1'b1;
    wait_ev(0, b_rd0 + 1);
    chk("t5_b_addr", 32'(last_cmd_addr), 32'h200ABC);
    wait_ev(3, b_ben0);
    chk("t5_b_rdata", 32'(last_b_rdata), 32'(mem_val(22'h200ABC)));
    b_rd = 1'b0; tick();

    // reset during WAIT_DATA with a late strobe
    resp_lat = 5;
    b_rd0 = n_rd; b_aen0 = n_aen;
    a_address = 22'h000DEF; a_rd = 1'b1;
    wait_ev(0, b_rd0);
    tick(); tick();
    reset = 1'b1; a_rd = 1'b0;
    tick();
    chk("t6_rst_strobes", 32'({ram_rd, ram_wr, a_rdata_en, b_rdata_en, a_busy, b_busy}), 0);
    chk("t6_rst_ram_address", 32'(ram_address), 0);
    chk("t6_rst_data", 32'({ram_wdata, a_rdata, b_rdata}), 0);
    reset = 1'b0;
    repeat (6) tick();
    chk("t6_no_late_en", n_aen - b_aen0, 0);
    resp_lat = 1;
    b_ben0 = n_ben;
    b_address = 22'h200DEF;
    a_rd = 1'b1; b_rd = 1'b1;
    wait_ev(0, b_rd0 + 1);
    chk("t6_first_after_reset", 32'(last_cmd_addr), 32'h000DEF);
    wait_ev(3, b_ben0);
    a_rd = 1'b0; b_rd = 1'b0;
    tick(); tick();

    // randomized traffic from both ports
    have_prev = 1'b0;
    base_cmd = n_rd + n_wr;
    done = 1'b0;
    rand_on = 1'b1;
    fork
      begin
        fork
          req_loop(1'b0, NRAND);
          req_loop(1'b1, NRAND);
        join
        done = 1'b1;
      end
      begin
        while (!done) begin
          tick();
          ram_busy = ($urandom_range(0, 3) == 0);
        end
      end
    join
    ram_busy = 1'b0;
    tick(); tick();
    rand_on = 1'b0;
    chk("rand_cmd_total", n_rd + n_wr - base_cmd, 2 * NRAND);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
